// File: rtl/timer_dev_if.sv
// Data-memory bus slice between the CPU/bridge and the countdown timer.
interface timer_dev_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output Addr, output WE, output WD, input RD);
    modport slave  (input Addr, input WE, input WD, output RD);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the CPU data-memory bus; raises IRQ when COUNT expires.
// Build macro TIMER_PRESCALE_EN inserts a PRESCALE-cycle prescaler in front of each count step.
module timer_dev #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus,
    output logic       IRQ
);
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    localparam logic [1:0]       ModeReload = 2'b01;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             step;
    logic             wr_ctrl, wr_preset;
    logic             unused_bus;

    assign wr_ctrl    = bus.WE && (bus.Addr[3:2] == 2'd0);
    assign wr_preset  = bus.WE && (bus.Addr[3:2] == 2'd1);
    assign unused_bus = ^{bus.Addr[31:4], bus.Addr[1:0], bus.WD};

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned    PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [PsW-1:0] ps_q, ps_d;

    assign step = (ps_q == PsLast);

    always_comb begin
        ps_d = ps_q;
        if (state_q == StLoad) begin
            ps_d = '0;
        end else if (state_q == StCnt && en_q) begin
            ps_d = step ? '0 : ps_q + PsW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic [31:0] unused_prescale;

    assign unused_prescale = PRESCALE;
    assign step            = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_q) state_d = StLoad;
            StLoad:  state_d = StCnt;
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (step && count_q <= CntOne) begin
                    state_d = StInt;
                end
            end
            StInt:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (state_q == StLoad) begin
            count_d = preset_q;
        end else if (state_q == StCnt && en_q && step) begin
            count_d = (count_q > CntOne) ? count_q - CntOne : '0;
        end

        if (wr_preset) begin
            preset_d = bus.WD[CNT_W-1:0];
        end

        // A CPU write to CTRL overrides whatever the expiry would have done this cycle.
        if (wr_ctrl) begin
            en_d   = bus.WD[0];
            mode_d = bus.WD[2:1];
            im_d   = bus.WD[3];
            flag_d = 1'b0;
        end else if (state_q == StInt) begin
            flag_d = 1'b1;
            if (mode_q != ModeReload) en_d = 1'b0;
        end else if (mode_q == ModeReload) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        bus.RD = '0;
        unique case (bus.Addr[3:2])
            2'd0:    bus.RD = {28'b0, im_q, mode_q, en_q};
            2'd1:    bus.RD = 32'(preset_q);
            2'd2:    bus.RD = 32'(count_q);
            default: bus.RD = '0;
        endcase
    end

    assign IRQ = flag_q & im_q;
endmodule
